// File: rtl/inner_rx_pkg.sv
// Shared constants and width helpers for the inner_iface receive path.
package inner_rx_pkg;

    localparam int IRX_DW = 8;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int irx_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/inner_iface.sv
// Push-only beat interface with no backpressure: the producer drives data/valid,
// the consumer must take every valid beat.
interface inner_iface;
    import inner_rx_pkg::*;

    logic [IRX_DW-1:0] data;
    logic              valid;

    modport master (output data, output valid);
    modport slave  (input  data, input  valid);

endinterface

// File: rtl/inner_rx_ram.sv
// DEPTH x IRX_DW storage for the receive FIFO: one synchronous write port and
// one asynchronous read port. Storage is deliberately not reset; the pointers
// and level in the parent decide which entries are meaningful.
module inner_rx_ram
    import inner_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = irx_ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PW-1:0]     waddr,
    input  logic [IRX_DW-1:0] wdata,
    input  logic [PW-1:0]     raddr,
    output logic [IRX_DW-1:0] rdata
);

    logic [IRX_DW-1:0] mem [DEPTH];

    // Write the incoming beat into its slot on the clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inner_slave_rx.sv
// Receive side of inner_iface. Every valid beat is captured into a small FIFO
// and re-presented on a valid/ready stream. When the FIFO is full and nothing
// leaves in the same cycle, the beat is dropped and counted instead of stalling.
module inner_slave_rx
    import inner_rx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int CNT_W    = 16,
    localparam int PW = irx_ptr_w(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    inner_iface.slave         ifc,
    output logic              out_valid,
    output logic [IRX_DW-1:0] out_data,
    input  logic              out_ready,
    output logic [LW-1:0]     level,
    output logic              almost_full,
    output logic              ovf,
    output logic [CNT_W-1:0]  ovf_cnt,
    input  logic              clr_ovf
);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     level_next;
    logic [IRX_DW-1:0] head_data;
    logic              push;
    logic              pop;
    logic              full;
    logic              accept;
    logic              drop;

    // A pop frees the head slot on the same edge, so a full FIFO can still
    // accept a push when the consumer takes a beat in that cycle.
    assign push   = ifc.valid;
    assign full   = (level == LW'(DEPTH));
    assign pop    = out_valid & out_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? head_data : '0;

    inner_rx_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata (ifc.data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    // Next occupancy: up on an accepted push, down on a pop, unchanged on both.
    always_comb begin
        level_next = level;
        if (accept && !pop) begin
            level_next = level + LW'(1);
        end else if (!accept && pop) begin
            level_next = level - LW'(1);
        end
    end

    // Pointers, occupancy and the registered almost_full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level       <= level_next;
            almost_full <= (level_next >= LW'(AF_LEVEL));
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (clr_ovf) begin
                ovf_cnt <= CNT_W'(1);
            end else if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end
    end

    // An unknown valid must never be mistaken for a push.
    a_valid_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(ifc.valid));

endmodule

// File: tb/tb_inner_slave_rx.sv
// Directed, table-driven bench for inner_slave_rx with hand-written sequences
// for the wrap, asynchronous reset and counter saturation cases.
module tb_inner_slave_rx;

    logic       clk;
    logic       rst_n;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [3:0] level;
    logic       almost_full;
    logic       ovf;
    logic [7:0] ovf_cnt;
    logic       clr_ovf;

    int tests_run;
    int tests_failed;

    inner_iface ifc_i ();

    inner_slave_rx #(
        .DEPTH    (8),
        .AF_LEVEL (6),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifc         (ifc_i),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .level       (level),
        .almost_full (almost_full),
        .ovf         (ovf),
        .ovf_cnt     (ovf_cnt),
        .clr_ovf     (clr_ovf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       clr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [3:0] exp_level;
        logic       exp_af;
        logic       exp_ovf;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(string name, logic v, logic [7:0] d, logic r, logic c,
                                   logic ev, logic [7:0] ed, logic [3:0] el,
                                   logic eaf, logic eovf, logic [7:0] ecnt);
        vec_t x;
        x.name = name; x.valid = v; x.data = d; x.ready = r; x.clr = c;
        x.exp_valid = ev; x.exp_data = ed; x.exp_level = el;
        x.exp_af = eaf; x.exp_ovf = eovf; x.exp_cnt = ecnt;
        vecs.push_back(x);
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
    task automatic applyStimulus(logic v, logic [7:0] d, logic r, logic c);
        ifc_i.valid = v;
        ifc_i.data  = d;
        out_ready   = r;
        clr_ovf     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(string name, logic ev, logic [7:0] ed, logic [3:0] el,
                            logic eaf, logic eovf, logic [7:0] ecnt);
        checkOutput({name, ".valid"}, 32'(out_valid), 32'(ev));
        checkOutput({name, ".data"},  32'(out_data),  32'(ed));
        checkOutput({name, ".level"}, 32'(level),     32'(el));
        checkOutput({name, ".af"},    32'(almost_full), 32'(eaf));
        checkOutput({name, ".ovf"},   32'(ovf),       32'(eovf));
        checkOutput({name, ".cnt"},   32'(ovf_cnt),   32'(ecnt));
    endtask

    logic [7:0] q[$];
    logic [7:0] nd;

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Vector table: tests 1-4 up to the push-while-popping-full case.
        addVec("t1_push", 1, 8'hAB, 1, 0, 1, 8'hAB, 1, 0, 0, 0);
        addVec("t1_pop",  0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            addVec($sformatf("t2_fill%0d", k), 1, 8'(k), 0, 0, 1, 8'h01, 4'(k), (k >= 6), 0, 0);
        addVec("t3_drop1", 1, 8'hAA, 0, 0, 1, 8'h01, 8, 1, 1, 1);
        addVec("t3_drop2", 1, 8'hBB, 0, 0, 1, 8'h01, 8, 1, 1, 2);
        addVec("t3_drop3", 1, 8'hCC, 0, 0, 1, 8'h01, 8, 1, 1, 3);
        addVec("t3_clr",   0, 8'h00, 0, 1, 1, 8'h01, 8, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            addVec($sformatf("t2_pop%0d", k), 0, 8'h00, 1, 0, (k < 8),
                   (k < 8) ? 8'(k + 1) : 8'h00, 4'(8 - k), ((8 - k) >= 6), 0, 0);
        for (int k = 0; k < 8; k++)
            addVec($sformatf("t4_fill%0d", k), 1, 8'(8'h10 + k), 0, 0, 1, 8'h10, 4'(k + 1), ((k + 1) >= 6), 0, 0);
        addVec("t4_full_pushpop", 1, 8'hFF, 1, 0, 1, 8'h11, 8, 1, 0, 0);

        // Reset and check the reset state.
        rst_n = 1'b0;
        ifc_i.valid = 1'b0;
        ifc_i.data  = 8'h00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #12;
        checkAll("reset", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ready, vecs[i].clr);
            checkAll(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_level,
                     vecs[i].exp_af, vecs[i].exp_ovf, vecs[i].exp_cnt);
        end

        // Continuous push/pop on a full FIFO across pointer wrap, then drain.
        q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hFF};
        for (int i = 0; i < 20; i++) begin
            nd = 8'(8'h40 + i);
            applyStimulus(1, nd, 1, 0);
            void'(q.pop_front());
            q.push_back(nd);
            checkOutput($sformatf("t4_wrap%0d.data", i), 32'(out_data), 32'(q[0]));
            checkOutput($sformatf("t4_wrap%0d.level", i), 32'(level), 32'd8);
        end
        checkOutput("t4_wrap.ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t4_drain%0d.data", i), 32'(out_data), 32'(q[0]));
            applyStimulus(0, 8'h00, 1, 0);
            void'(q.pop_front());
        end
        checkOutput("t4_drain.level", 32'(level), 32'd0);

        // Build level 5 with a nonzero drop count, then reset mid-cycle.
        for (int k = 0; k < 8; k++) applyStimulus(1, 8'(8'h60 + k), 0, 0);
        applyStimulus(1, 8'hEE, 0, 0);
        applyStimulus(1, 8'hEE, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 1, 0);
        checkAll("t5_pre", 1, 8'h63, 5, 0, 1, 2);
        ifc_i.valid = 1'b0;
        out_ready   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("t5_async", 0, 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h00, 1, 0);
        checkAll("t5_idle", 0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 8'h5A, 0, 0);
        checkAll("t5_first", 1, 8'h5A, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        checkAll("t5_pop", 0, 8'h00, 0, 0, 0, 0);

        // Clear colliding with a drop, then saturate the counter.
        for (int k = 0; k < 8; k++) applyStimulus(1, 8'(8'h70 + k), 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 8'hDD, 0, 0);
        checkAll("t6_cnt4", 1, 8'h70, 8, 1, 1, 4);
        applyStimulus(1, 8'hDD, 0, 1);
        checkAll("t6_clr_drop", 1, 8'h70, 8, 1, 1, 1);
        for (int k = 0; k < 300; k++) applyStimulus(1, 8'hDD, 0, 0);
        checkAll("t6_sat", 1, 8'h70, 8, 1, 1, 8'hFF);
        applyStimulus(1, 8'hDD, 0, 0);
        checkOutput("t6_sat_hold", 32'(ovf_cnt), 32'hFF);
        applyStimulus(0, 8'h00, 0, 1);
        checkAll("t6_clr", 1, 8'h70, 8, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
